// File: rtl/riscv_ex_muldiv_stage_if.sv
// Operand, control and result bundle between register-read, the execute stage and memory.
// The execute stage uses the slave view; the producer/consumer side uses the master view.
interface riscv_ex_muldiv_stage_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] immediate;
    logic [4:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic [2:0]      br_cond;
    logic            jump;
    logic            jalr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] branch_target;
    logic            branch_taken;
    logic            busy;

    modport master (
        output flush, in_valid, pc, rs1_data, rs2_data, immediate, alu_op, alu_src,
               branch, br_cond, jump, jalr, out_ready,
        input  in_ready, out_valid, alu_result, branch_target, branch_taken, busy
    );

    modport slave (
        input  flush, in_valid, pc, rs1_data, rs2_data, immediate, alu_op, alu_src,
               branch, br_cond, jump, jalr, out_ready,
        output in_ready, out_valid, alu_result, branch_target, branch_taken, busy
    );
endinterface

// File: rtl/riscv_ex_muldiv_stage.sv
// Execute stage: single-cycle ALU/branch/jump plus an iterative shift-add multiplier
// and restoring divider, with valid/ready on both sides and a flush for redirects.
//
// state  | meaning
// S_IDLE | accepting ops; single-cycle results load directly
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
module riscv_ex_muldiv_stage #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst_n,
    riscv_ex_muldiv_stage_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              finish;

    logic              out_valid_q;
    logic [XLEN-1:0]   result_q, target_q;
    logic              taken_q;

    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   mcand_q, quo_q, rem_q;
    logic              neg_q, rneg_q, hi_q, rsel_q;

    logic [XLEN-1:0]   op2, alu_val, target_val, mag_a, mag_b;
    logic [SHW-1:0]    shamt;
    logic              accept, cond, taken_val, sa, sb;
    logic              is_mul, is_div, div0, ovf, div_special;
    logic              go_mul, go_div, load_single;

    logic [XLEN:0]     mul_sum, r_shift;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   quo_step, rem_step, q_fix, r_fix, iter_result;
    logic              ge;

    assign op2   = bus.alu_src ? bus.immediate : bus.rs2_data;
    assign shamt = op2[SHW-1:0];

    assign bus.in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready)
                          && !bus.flush;
    assign accept = bus.in_valid && bus.in_ready;

    assign is_mul      = bus.alu_op inside {5'd10, 5'd11, 5'd12, 5'd13};
    assign is_div      = bus.alu_op inside {5'd14, 5'd15, 5'd16, 5'd17};
    assign div0        = (op2 == '0);
    assign ovf         = (bus.rs1_data == XMIN) && (op2 == '1)
                         && (bus.alu_op inside {5'd14, 5'd16});
    assign div_special = is_div && (div0 || ovf);

    assign go_mul      = accept && !bus.jump && is_mul;
    assign go_div      = accept && !bus.jump && is_div && !div_special;
    assign load_single = accept && !go_mul && !go_div;

    // Operand signedness: MULHSU treats only rs1 as signed; MULHU/DIVU/REMU neither.
    assign sa    = bus.rs1_data[XLEN-1] && (bus.alu_op inside {5'd10, 5'd11, 5'd12, 5'd14, 5'd16});
    assign sb    = op2[XLEN-1] && (bus.alu_op inside {5'd10, 5'd11, 5'd14, 5'd16});
    assign mag_a = sa ? -bus.rs1_data : bus.rs1_data;
    assign mag_b = sb ? -op2 : op2;

    always_comb begin
        alu_val = '0;
        case (bus.alu_op)
            5'd0:  alu_val = bus.rs1_data + op2;
            5'd1:  alu_val = bus.rs1_data - op2;
            5'd2:  alu_val = bus.rs1_data & op2;
            5'd3:  alu_val = bus.rs1_data | op2;
            5'd4:  alu_val = bus.rs1_data ^ op2;
            5'd5:  alu_val = bus.rs1_data << shamt;
            5'd6:  alu_val = bus.rs1_data >> shamt;
            5'd7:  alu_val = $unsigned($signed(bus.rs1_data) >>> shamt);
            5'd8:  alu_val = {{(XLEN-1){1'b0}}, $signed(bus.rs1_data) < $signed(op2)};
            5'd9:  alu_val = {{(XLEN-1){1'b0}}, bus.rs1_data < op2};
            5'd14: alu_val = div0 ? '1 : XMIN;
            5'd15: alu_val = '1;
            5'd16: alu_val = div0 ? bus.rs1_data : '0;
            5'd17: alu_val = bus.rs1_data;
            default: alu_val = '0;
        endcase
        if (bus.jump) alu_val = bus.pc + XLEN'(4);
    end

    always_comb begin
        cond = 1'b0;
        case (bus.br_cond)
            3'b000: cond = (bus.rs1_data == bus.rs2_data);
            3'b001: cond = (bus.rs1_data != bus.rs2_data);
            3'b100: cond = $signed(bus.rs1_data) <  $signed(bus.rs2_data);
            3'b101: cond = $signed(bus.rs1_data) >= $signed(bus.rs2_data);
            3'b110: cond = bus.rs1_data <  bus.rs2_data;
            3'b111: cond = bus.rs1_data >= bus.rs2_data;
            default: cond = 1'b0;
        endcase
    end

    assign taken_val  = bus.jump || (bus.branch && cond);
    assign target_val = bus.jalr ? ((bus.rs1_data + bus.immediate) & {{(XLEN-1){1'b1}}, 1'b0})
                                 : (bus.pc + bus.immediate);

    // One iteration step of each unit; the final step feeds the sign fix directly.
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_fix  = neg_q ? -prod_step : prod_step;

    assign r_shift  = {rem_q, quo_q[XLEN-1]};
    assign ge       = (r_shift >= {1'b0, mcand_q});
    assign rem_step = ge ? (r_shift[XLEN-1:0] - mcand_q) : r_shift[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ge};
    assign q_fix    = neg_q ? -quo_step : quo_step;
    assign r_fix    = rneg_q ? -rem_step : rem_step;

    always_comb begin
        iter_result = '0;
        if (state_q == S_MUL) iter_result = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        else                  iter_result = rsel_q ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_mul) begin
                    state_d = S_MUL;
                    cnt_d   = CW'(XLEN-1);
                end else if (go_div) begin
                    state_d = S_DIV;
                    cnt_d   = CW'(XLEN-1);
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            target_q    <= '0;
            taken_q     <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load_single) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_val;
            target_q    <= target_val;
            taken_q     <= taken_val;
        end else if (finish) begin
            out_valid_q <= 1'b1;
            result_q    <= iter_result;
            target_q    <= '0;
            taken_q     <= 1'b0;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (go_mul) begin
            mcand_q <= mag_a;
            prod_q  <= {{XLEN{1'b0}}, mag_b};
            neg_q   <= sa ^ sb;
            hi_q    <= (bus.alu_op != 5'd10);
        end else if (go_div) begin
            quo_q   <= mag_a;
            rem_q   <= '0;
            mcand_q <= mag_b;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            rsel_q  <= (bus.alu_op inside {5'd16, 5'd17});
        end else if (state_q == S_MUL) begin
            prod_q <= prod_step;
        end else if (state_q == S_DIV) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_result    = result_q;
    assign bus.branch_target = target_q;
    assign bus.branch_taken  = taken_q;
    assign bus.busy          = (state_q == S_MUL) || (state_q == S_DIV);
endmodule

// File: doc/riscv_ex_muldiv_stage.md
# riscv_ex_muldiv_stage

Parametrised execute stage for the RISC-V mini core. It is the successor to the single-cycle execute block and adds:
- configurable datapath width;
- the full RV32I ALU op set, all six branch conditions, and JAL/JALR link and target generation;
- an iterative RV32M multiply/divide unit.

It sits between the decode/register-read stage and memory stage. It uses valid/ready handshakes on both sides so that multi-cycle ops stall upstream, and it has a flush input for branch redirect.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8, power of two)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- flush  in  1  synchronous kill of in-flight/held op
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept op this cycle
- pc  in  XLEN  instruction PC
- rs1_data, rs2_data  in  XLEN  operands
- immediate  in  XLEN  sign-extended immediate
- alu_op  in  5  operation select (see Operation)
- alu_src  in  1  1: operand2=immediate, 0: rs2_data
- branch  in  1  conditional branch
- br_cond  in  3  branch funct3
- jump  in  1  JAL/JALR
- jalr  in  1  with jump: target from rs1
- out_valid  out  1  result register valid
- out_ready  in  1  downstream accepts result
- alu_result  out  XLEN  registered result
- branch_target  out  XLEN  registered target
- branch_taken  out  1  registered taken flag
- busy  out  1  iterative unit active

## Operation
- Accept: in_valid && in_ready at a rising edge. in_ready = state==IDLE && (!out_valid || out_ready) && !flush.
- Single-cycle alu_op values (op2 = alu_src ? immediate : rs2_data):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA, using shamt = op2[log2(XLEN)-1:0];
  - 8 SLT, 9 SLTU, producing a zero-extended 1-bit result.
- Multi-cycle alu_op values: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- alu_op 18–31: result 0, single-cycle.
- Arithmetic is modulo 2^XLEN. MULH* returns the upper XLEN bits of the 2·XLEN product with the RV32M signedness.
- Multiply is shift-add, one bit per cycle, on the magnitudes with a sign fix at the end. Divide is restoring, one bit per cycle, on magnitudes with sign fix.
- Divide special cases bypass iteration and complete as single-cycle ops:
  - divisor 0: quotient all-ones, remainder = dividend;
  - signed MIN/−1: quotient MIN, remainder 0.
- Branch compare always uses rs1_data vs rs2_data, independent of alu_op:
  - br_cond 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU;
  - 010/011 never taken.
- branch_taken = jump | (branch && cond).
- branch_target = jalr ? (rs1_data+immediate) & ~1 : pc+immediate.
- When jump=1, alu_result = pc+4, overriding alu_op.
- FSM states:
  - IDLE: on accept of op 10–17 (non-special) go to MUL or DIV. Otherwise load output registers and stay in IDLE.
  - MUL/DIV: iterate; counter counts XLEN-1 down to 0. At 0, load the output registers and go to IDLE.
- busy = state∈{MUL,DIV}.
- Output hold: out_valid cleared on out_ready, unless a new result is loaded the same edge. Output registers are stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low at an edge):
  - state IDLE, counter 0, out_valid 0, alu_result 0, branch_target 0, branch_taken 0, busy 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
  - Reset mid-iteration discards the operation.
- Single-cycle op accepted at edge N: out_valid=1 after edge N. Back-to-back throughput is 1/cycle when out_ready=1.
- Iterative op accepted at edge N:
  - busy=1 after edge N;
  - result loaded and out_valid=1 after edge N+XLEN; busy=0 at the same edge;
  - in_ready is 0 for cycles N+1..N+XLEN.
- Branch/jump fields are captured at accept and loaded with the result. For iterative ops, branch_taken and branch_target register as 0.
- flush at edge: clears out_valid, aborts MUL/DIV to IDLE, and blocks acceptance that cycle (flush wins over in_valid and over result completion).
- Simultaneous out_ready and new accept: the old result retires and the new one loads at the same edge (no bubble).

## Test plan
- Reset, then ADD with rs1=5, rs2=7, alu_src=0 → out_valid next cycle, alu_result=12. With immediate −3 and alu_src=1 → alu_result=2.
- SRA rs1=0x80000000, op2=4 → 0xF8000000. SLTU with rs1=1, rs2=0xFFFFFFFF → 1. BLT signed with rs1=−1, rs2=1 → branch_taken=1, branch_target=pc+immediate.
- MULH rs1=0x80000000, rs2=2 → in_ready low 32 cycles, out_valid 33rd edge, result 0xFFFFFFFF. MULHU with same operands → 0x00000001.
- Division special cases, each completing in 1 cycle with busy never set:
  - DIV 7/0 → 0xFFFFFFFF;
  - REM 7/0 → 7;
  - DIV 0x80000000/−1 → 0x80000000;
  - REM of the same → 0.
- DIV −7/2 → −3 and REM −7/2 → −1. With out_ready held low 5 cycles after completion, outputs stay stable and in_ready stays 0 until retire.
- flush asserted on cycle 10 of a DIVU → busy=0 and out_valid=0 next edge, no result emitted. JALR with rs1=0x1001, imm=4 then yields target 0x1004 and alu_result=pc+4.
